// File: rtl/exec_unit_mc.sv
// -----------------------------------------------------------------------------
// exec_unit_mc
//   Small execution unit. It handles single-cycle ALU and branch operations,
//   and a multi-cycle shift-add multiplier. It keeps an NZCV flag register
//   that an operation updates only when it asks to.
//
// Parameters
//   DATA_W        operand / result / multiplier width
//   IMM_W         immediate width (sign-extended to DATA_W; IMM_W < DATA_W)
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   in_valid      operation presented this cycle
//   in_ready      unit can accept (low while a multiply is running)
//   op            000 MOV, 001 ADD, 010 SUB, 011 NOT, 100 CLR, 101 MUL,
//                 110 BR, 111 reserved
//   use_imm       operand B = sext(imm) instead of src_b
//   set_flags     commit NZCV from this operation
//   src_a, src_b  register operands
//   imm           signed immediate
//   cond          branch condition for BR
//   out_valid     one-cycle completion pulse
//   result        operation result
//   write_en      result is to be written back
//   branch_taken  BR condition evaluated true
//   flags_out     NZCV register (N=3, Z=2, C=1, V=0)
// -----------------------------------------------------------------------------
module exec_unit_mc #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic              use_imm,
  input  logic              set_flags,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic [IMM_W-1:0]  imm,
  input  logic [3:0]        cond,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic              write_en,
  output logic              branch_taken,
  output logic [3:0]        flags_out
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int MSB   = DATA_W - 1;

  typedef enum logic [2:0] {
    OP_MOV = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_NOT = 3'b011,
    OP_CLR = 3'b100,
    OP_MUL = 3'b101,
    OP_BR  = 3'b110,
    OP_RSV = 3'b111
  } op_t;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    count;
  logic [3:0]          nzcv;
  logic [DATA_W-1:0]   mul_a;    // multiplicand, shifts left each step
  logic [DATA_W-1:0]   mul_b;    // multiplier, shifts right each step
  logic [DATA_W-1:0]   mul_acc;
  logic                mul_sf;   // set_flags captured at MUL accept

  op_t                 op_dec;
  logic [DATA_W-1:0]   operand_b;
  logic [DATA_W:0]     add_full;
  logic [DATA_W:0]     sub_full;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_we;
  logic                alu_flags_ok; // op defines flags (not BR / reserved)
  logic [3:0]          alu_flags;
  logic                br_taken;
  logic [DATA_W-1:0]   mul_partial;

  assign op_dec    = op_t'(op);
  assign operand_b = use_imm ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm} : src_b;
  assign add_full  = {1'b0, src_a} + {1'b0, operand_b};
  assign sub_full  = {1'b0, src_a} - {1'b0, operand_b};

  // Accept only happens in IDLE; the multiplier owns the unit while running.
  assign in_ready  = (state == S_IDLE);
  assign flags_out = nzcv;

  // One shift-add partial-product step.
  assign mul_partial = mul_acc + (mul_b[0] ? mul_a : '0);

  // Branch condition against the committed NZCV register.
  always_comb begin
    br_taken = 1'b0;
    case (cond)
      4'b0000: br_taken =  nzcv[2];
      4'b0001: br_taken = ~nzcv[2];
      4'b0010: br_taken =  nzcv[1];
      4'b0011: br_taken = ~nzcv[1];
      4'b0100: br_taken =  nzcv[3];
      4'b0101: br_taken = ~nzcv[3];
      4'b0110: br_taken =  nzcv[0];
      4'b0111: br_taken = ~nzcv[0];
      4'b1110: br_taken =  1'b1;
      default: br_taken =  1'b0;
    endcase
  end

  // Single-cycle datapath.
  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    alu_result   = '0;
    alu_we       = 1'b0;
    alu_flags_ok = 1'b0;
    alu_flags    = 4'b0000;
    case (op_dec)
      OP_MOV: begin
        alu_result   = operand_b;
        alu_we       = 1'b1;
        alu_flags_ok = 1'b1;
      end
      OP_ADD: begin
        alu_result   = add_full[MSB:0];
        alu_we       = 1'b1;
        alu_flags_ok = 1'b1;
        alu_flags[1] = add_full[DATA_W];
        alu_flags[0] = (src_a[MSB] == operand_b[MSB]) &&
                       (add_full[MSB] != src_a[MSB]);
      end
      OP_SUB: begin
        alu_result   = sub_full[MSB:0];
        alu_we       = 1'b1;
        alu_flags_ok = 1'b1;
        // Carry is the inverse of the borrow out of the top bit.
        alu_flags[1] = ~sub_full[DATA_W];
        alu_flags[0] = (src_a[MSB] != operand_b[MSB]) &&
                       (sub_full[MSB] != src_a[MSB]);
      end
      OP_NOT: begin
        alu_result   = ~src_a;
        alu_we       = 1'b1;
        alu_flags_ok = 1'b1;
      end
      OP_CLR: begin
        alu_result   = '0;
        alu_we       = 1'b1;
        alu_flags_ok = 1'b1;
      end
      default: begin
        // BR, reserved (MUL never completes through this path).
        alu_result   = '0;
      end
    endcase
    alu_flags[3] = alu_result[MSB];
    alu_flags[2] = (alu_result == '0);
  end

  // Control FSM with registered outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the multiplier datapath is cleared as well, so an aborted
      // multiply leaves no stale operands behind.
      state        <= S_IDLE;
      count        <= '0;
      nzcv         <= 4'b0000;
      out_valid    <= 1'b0;
      write_en     <= 1'b0;
      branch_taken <= 1'b0;
      result       <= '0;
      mul_a        <= '0;
      mul_b        <= '0;
      mul_acc      <= '0;
      mul_sf       <= 1'b0;
    end else begin
      out_valid    <= 1'b0;
      write_en     <= 1'b0;
      branch_taken <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (op_dec == OP_MUL) begin
              mul_a   <= src_a;
              mul_b   <= operand_b;
              mul_acc <= '0;
              mul_sf  <= set_flags;
              count   <= CNT_W'(DATA_W);
              state   <= S_RUN;
            end else begin
              out_valid    <= 1'b1;
              result       <= alu_result;
              write_en     <= alu_we;
              branch_taken <= (op_dec == OP_BR) && br_taken;
              if (set_flags && alu_flags_ok) nzcv <= alu_flags;
            end
          end
        end
        S_RUN: begin
          // Fixed DATA_W steps; no early exit on zero operands.
          mul_acc <= mul_partial;
          mul_a   <= mul_a << 1;
          mul_b   <= mul_b >> 1;
          count   <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            result    <= mul_partial;
            out_valid <= 1'b1;
            write_en  <= 1'b1;
            state     <= S_IDLE;
            if (mul_sf) nzcv <= {mul_partial[MSB], (mul_partial == '0), 2'b00};
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
